byte_mem_responder: RTL

- Memory-side responder for the byte-masked request/hold memory interface. It terminates the mem* port driven by the byte-interface mux or a single initiator.
- Contains a DEPTH x DATA_BYTE-byte storage array and a configurable wait-state engine that generates hold.
- Read data is returned one cycle after acceptance.
- Out-of-range word addresses are flagged with an error pulse.

---
 rtl/byte_mem_responder_if.sv | 25 ++
 rtl/byte_mem_responder.sv | 106 ++++++++++
 2 files changed

// File: rtl/byte_mem_responder_if.sv
// Byte-masked request/hold memory bus between an initiator (or byte-interface mux)
// and a memory-side responder.
interface byte_mem_responder_if #(
    parameter int DATA_BYTE = 4,
    parameter int ADDR_SIZE = 32
);
    logic                     memEnable_i;
    logic                     memIsWrite_i;
    logic [DATA_BYTE-1:0]     memWriteMask_i;
    logic [ADDR_SIZE-1:0]     memAddr_i;
    logic [DATA_BYTE*8-1:0]   memWriteData_i;
    logic [DATA_BYTE*8-1:0]   memReadData_o;
    logic                     memHold_o;
    logic                     memErr_o;

    modport master (
        output memEnable_i, memIsWrite_i, memWriteMask_i, memAddr_i, memWriteData_i,
        input  memReadData_o, memHold_o, memErr_o
    );

    modport slave (
        input  memEnable_i, memIsWrite_i, memWriteMask_i, memAddr_i, memWriteData_i,
        output memReadData_o, memHold_o, memErr_o
    );
endinterface

// File: rtl/byte_mem_responder.sv
// Memory-side responder: DEPTH-word byte-maskable storage array with a
// configurable wait-state engine driving hold, registered read data and error pulse.
module byte_mem_responder #(
    parameter int DATA_BYTE   = 4,
    parameter int ADDR_SIZE   = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    byte_mem_responder_if.slave mem_if
);
    localparam int DW    = DATA_BYTE * 8;
    localparam int OFF_W = $clog2(DATA_BYTE);
    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] word_sel;
    logic             in_range;
    logic             hold;
    logic             accept;

    logic [DW-1:0]    mem_array [DEPTH];

    // Any address bit above the array's word index makes the access out of range.
    assign word_sel = mem_if.memAddr_i[OFF_W +: IDX_W];
    assign in_range = (mem_if.memAddr_i >> (OFF_W + IDX_W)) == '0;

    // Reset gates acceptance so a request present at a reset edge never touches the array.
    assign accept          = mem_if.memEnable_i & ~hold & ~rst_i;
    assign mem_if.memHold_o = hold;

    generate
        if (WAIT_CYCLES == 0) begin : g_no_wait
            assign hold = 1'b0;
        end else begin : g_wait
            typedef enum logic [1:0] {
                IDLE,
                WAIT,
                READY
            } state_t;

            localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

            state_t     state;
            logic [3:0] cnt;

            // Hold follows enable combinationally until the countdown reaches READY.
            assign hold = mem_if.memEnable_i && (state != READY);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (mem_if.memEnable_i) begin
                                cnt   <= CNT_INIT;
                                state <= (WAIT_CYCLES > 1) ? WAIT : READY;
                            end
                        end
                        WAIT: begin
                            if (!mem_if.memEnable_i) begin
                                state <= IDLE;
                            end else begin
                                cnt <= cnt - 4'd1;
                                if (cnt == 4'd1) begin
                                    state <= READY;
                                end
                            end
                        end
                        READY: begin
                            state <= IDLE;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Storage is deliberately not reset; only masked bytes of in-range writes change.
    always_ff @(posedge clk_i) begin
        if (accept && mem_if.memIsWrite_i && in_range) begin
            for (int k = 0; k < DATA_BYTE; k++) begin
                if (mem_if.memWriteMask_i[k]) begin
                    mem_array[word_sel][8*k +: 8] <= mem_if.memWriteData_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_if.memReadData_o <= '0;
            mem_if.memErr_o      <= 1'b0;
        end else begin
            mem_if.memErr_o <= accept && !in_range;
            if (accept && !mem_if.memIsWrite_i) begin
                mem_if.memReadData_o <= in_range ? mem_array[word_sel] : '0;
            end
        end
    end
endmodule
